// File: rtl/seq_matcher_pkg.sv
// Shared types for the sequence matcher: FSM state encoding, step record and match helper.
package seq_matcher_pkg;

   localparam int unsigned MAX_IN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [MAX_IN-1:0] mask;
      logic [MAX_IN-1:0] val;
   } step_t;

   // A step matches when every cared bit equals its required value.
   function automatic logic step_match(input logic [MAX_IN-1:0] bits, input step_t s);
      return ((bits ^ s.val) & s.mask) == '0;
   endfunction

endpackage

// File: rtl/seq_step_table.sv
// Step table: DEPTH entries of (mask, val), one write port, two combinational read ports.
module seq_step_table
   import seq_matcher_pkg::*;
#(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned DEPTH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [N_IN-1:0]          wmask,
   input  logic [N_IN-1:0]          wval,
   input  logic [$clog2(DEPTH)-1:0] raddr_a,
   input  logic [$clog2(DEPTH)-1:0] raddr_b,
   output step_t                    rd_a,
   output step_t                    rd_b
);

   logic [N_IN-1:0] mask_q [DEPTH];
   logic [N_IN-1:0] val_q  [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mask_q[i] <= '0;
            val_q[i]  <= '0;
         end
      end else if (we && (32'(waddr) < DEPTH)) begin
         mask_q[waddr] <= wmask;
         val_q[waddr]  <= wval;
      end
   end

   // Out-of-range reads return an all-zero (always matching) record.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (32'(raddr_a) < DEPTH) begin
         rd_a.mask = MAX_IN'(mask_q[raddr_a]);
         rd_a.val  = MAX_IN'(val_q[raddr_a]);
      end
      if (32'(raddr_b) < DEPTH) begin
         rd_b.mask = MAX_IN'(mask_q[raddr_b]);
         rd_b.val  = MAX_IN'(val_q[raddr_b]);
      end
   end

endmodule

// File: rtl/seq_matcher.sv
// Sampled multi-step input pattern matcher with per-step hold timeout.
module seq_matcher
   import seq_matcher_pkg::*;
#(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned DEPTH = 12,
   parameter int unsigned TO_W  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       sample,
   input  logic [N_IN-1:0]            in_bits,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [N_IN-1:0]            cfg_mask,
   input  logic [N_IN-1:0]            cfg_val,
   input  logic [TO_W-1:0]            timeout,
   output logic [$clog2(DEPTH+1)-1:0] step_idx,
   output logic                       active,
   output logic                       matched,
   output logic                       fail
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned IDX_W  = $clog2(DEPTH+1);

   logic              rst_meta;
   logic              rst_n;
   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  idx_d;
   logic [TO_W-1:0]   hold_q;
   logic [TO_W-1:0]   hold_d;
   logic              fail_d;
   logic [ADDR_W-1:0] raddr_a;
   logic [ADDR_W-1:0] raddr_b;
   step_t             step_cur;
   step_t             step_prev;
   logic              hit_cur;
   logic              hit_prev;
   logic              hold_expired;
   logic              last_step;

   // Assert asynchronously, release two edges after reset deasserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   seq_step_table #(
      .N_IN  (N_IN),
      .DEPTH (DEPTH)
   ) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (cfg_we && !enable),
      .waddr   (cfg_addr),
      .wmask   (cfg_mask),
      .wval    (cfg_val),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rd_a    (step_cur),
      .rd_b    (step_prev)
   );

   // Port a looks at step 0 outside RUN so IDLE can test the start condition.
   assign raddr_a      = (state_q == ST_RUN) ? ADDR_W'(step_idx) : '0;
   assign raddr_b      = ADDR_W'(step_idx - IDX_W'(1));
   assign hit_cur      = step_match(MAX_IN'(in_bits), step_cur);
   assign hit_prev     = step_match(MAX_IN'(in_bits), step_prev);
   assign hold_expired = (timeout != '0) && (hold_q == timeout);
   assign last_step    = (step_idx == IDX_W'(DEPTH - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = step_idx;
      hold_d  = hold_q;
      fail_d  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         hold_d  = '0;
      end else if (sample) begin
         case (state_q)
            ST_IDLE: begin
               if (hit_cur) begin
                  state_d = ST_RUN;
                  idx_d   = IDX_W'(1);
                  hold_d  = '0;
               end
            end
            ST_RUN: begin
               if (hit_cur) begin
                  idx_d  = step_idx + IDX_W'(1);
                  hold_d = '0;
                  if (last_step) state_d = ST_DONE;
               end else if (hit_prev && !hold_expired) begin
                  if (hold_q != '1) hold_d = hold_q + TO_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  hold_d  = '0;
                  fail_d  = 1'b1;
               end
            end
            ST_DONE: ;
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         step_idx <= '0;
         hold_q   <= '0;
         active   <= 1'b0;
         matched  <= 1'b0;
         fail     <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_idx <= idx_d;
         hold_q   <= hold_d;
         active   <= (state_d == ST_RUN);
         matched  <= (state_d == ST_DONE);
         fail     <= fail_d;
      end
   end

endmodule

// File: tb/tb_seq_matcher.sv
// Bench for seq_matcher: table-driven vectors plus hand sequences, scoreboard queue of expected outputs.
module tb_seq_matcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       sample;
   logic [3:0] in_bits;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [3:0] cfg_mask;
   logic [3:0] cfg_val;
   logic [7:0] timeout;
   logic [2:0] step_idx;
   logic       active;
   logic       matched;
   logic       fail;

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [2:0] idx;
      logic       act;
      logic       mat;
      logic       fl;
   } exp_t;

   typedef struct {
      logic       en;
      logic       smp;
      logic [3:0] bits;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   seq_matcher #(.N_IN(4), .DEPTH(4), .TO_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .sample   (sample),
      .in_bits  (in_bits),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_mask (cfg_mask),
      .cfg_val  (cfg_val),
      .timeout  (timeout),
      .step_idx (step_idx),
      .active   (active),
      .matched  (matched),
      .fail     (fail)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   function automatic exp_t ex(input int idx, input bit act, input bit mat, input bit fl);
      exp_t e;
      e.idx = 3'(idx);
      e.act = act;
      e.mat = mat;
      e.fl  = fl;
      return e;
   endfunction

   function automatic vec_t mk(input bit en, input bit smp, input logic [3:0] bits,
                               input int idx, input bit act, input bit mat, input bit fl);
      vec_t v;
      v.en   = en;
      v.smp  = smp;
      v.bits = bits;
      v.e    = ex(idx, act, mat, fl);
      return v;
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got !== want) $display("FAIL %s: got %0d expected %0d", nm, got, want);
      else passed++;
   endtask

   // Drive one cycle, queue its expectation, then compare the front entry after the edge.
   task automatic step(input logic en, input logic smp, input logic [3:0] bits,
                       input exp_t e, input string nm);
      exp_t x;
      enable  = en;
      sample  = smp;
      in_bits = bits;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({nm, ".idx"},     int'(step_idx), int'(x.idx));
      chk({nm, ".active"},  int'(active),   int'(x.act));
      chk({nm, ".matched"}, int'(matched),  int'(x.mat));
      chk({nm, ".fail"},    int'(fail),     int'(x.fl));
   endtask

   task automatic prog(input logic [1:0] a, input logic [3:0] m, input logic [3:0] v);
      enable   = 1'b0;
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_mask = m;
      cfg_val  = v;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      enable   = 1'b0;
      sample   = 1'b0;
      in_bits  = '0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_mask = '0;
      cfg_val  = '0;
      timeout  = 8'd3;

      vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1101, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1001, 3, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1010, 4, 0, 1, 0));
      vecs.push_back(mk(1, 1, 4'b0000, 4, 0, 1, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 4, 0, 1, 0));
      vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0100, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1101, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1101, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1101, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1101, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1101, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1111, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 4'b1101, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("reset.idx",     int'(step_idx), 0);
      chk("reset.active",  int'(active),   0);
      chk("reset.matched", int'(matched),  0);
      chk("reset.fail",    int'(fail),     0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Freshly reset table has all-zero masks, so every sample advances.
      for (int i = 1; i <= 4; i++)
         step(1, 1, 4'b1111, ex(i, i < 4, i == 4, 0), $sformatf("zero_tbl%0d", i));
      step(0, 0, 4'b0000, ex(0, 0, 0, 0), "zero_tbl_exit");

      prog(2'd0, 4'b0100, 4'b0100);
      prog(2'd1, 4'b1001, 4'b1001);
      prog(2'd2, 4'b0100, 4'b0000);
      prog(2'd3, 4'b0011, 4'b0010);

      foreach (vecs[i])
         step(vecs[i].en, vecs[i].smp, vecs[i].bits, vecs[i].e, $sformatf("vec%0d", i));

      // Sample gaps leave progress untouched, then a mismatch aborts.
      step(1, 1, 4'b0100, ex(1, 1, 0, 0), "gap_start");
      for (int i = 0; i < 10; i++)
         step(1, 0, 4'b0010, ex(1, 1, 0, 0), $sformatf("gap_a%0d", i));
      step(1, 1, 4'b0010, ex(0, 0, 0, 1), "gap_abort");
      for (int i = 0; i < 10; i++)
         step(1, 0, 4'b0100, ex(0, 0, 0, 0), $sformatf("gap_b%0d", i));

      // Zero timeout never expires a hold.
      timeout = 8'd0;
      step(1, 1, 4'b0100, ex(1, 1, 0, 0), "to0_start");
      for (int i = 0; i < 6; i++)
         step(1, 1, 4'b0100, ex(1, 1, 0, 0), $sformatf("to0_hold%0d", i));
      step(0, 0, 4'b0000, ex(0, 0, 0, 0), "to0_exit");
      timeout = 8'd3;

      // Table writes are ignored while enabled, accepted while disabled.
      cfg_we   = 1'b1;
      cfg_addr = 2'd0;
      cfg_mask = 4'b1111;
      cfg_val  = 4'b0000;
      step(1, 0, 4'b0000, ex(0, 0, 0, 0), "cfg_en_write");
      cfg_we = 1'b0;
      step(1, 1, 4'b0100, ex(1, 1, 0, 0), "cfg_old_start");
      cfg_we = 1'b1;
      step(0, 0, 4'b0000, ex(0, 0, 0, 0), "cfg_dis_write");
      cfg_we = 1'b0;
      step(1, 1, 4'b0100, ex(0, 0, 0, 0), "cfg_old_nostart");
      step(1, 1, 4'b0000, ex(1, 1, 0, 0), "cfg_new_start");
      step(1, 1, 4'b1101, ex(2, 1, 0, 0), "cfg_adv2");

      // Asynchronous reset mid-run clears outputs without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      chk("arst.idx",    int'(step_idx), 0);
      chk("arst.active", int'(active),   0);
      chk("arst.fail",   int'(fail),     0);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("arst_hold%0d.fail", i), int'(fail), 0);
         chk($sformatf("arst_hold%0d.idx", i),  int'(step_idx), 0);
      end
      do_reset();
      step(1, 1, 4'b0000, ex(1, 1, 0, 0), "post_rst_zero_tbl");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
